alu_cmd_sequencer: RTL
======================

// Module: alu_cmd_sequencer
// PURPOSE
//  Command-issue stage directly upstream of the Calc ALU. Accepts mnemonic ALU commands {op,x,y}
//  on a valid/ready port, buffers them in a FIFO, decodes op into {zx,nx,zy,ny,f,no} for the
//  ALU, and registers o/zr/ng into a valid/ready result port.
//  An accumulator holds the last result, so dependent commands can chain without a round trip.
// PARAMETERS
//  WIDTH  8  operand/result width (matches Calc)
//  DEPTH  4  command FIFO entries; power of 2, >=2
// PORTS
//  clk        in   1      system clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      command valid
//  in_ready   out  1      command accepted when in_valid&&in_ready
//  in_op      in   5      operation code (table below)
//  in_use_acc in   1      1: replace x with accumulator at execute time
//  in_x       in   WIDTH  x operand
//  in_y       in   WIDTH  y operand
//  alu_x      out  WIDTH  to Calc x
//  alu_y      out  WIDTH  to Calc y
//  alu_ctrl   out  6      to Calc {zx,nx,zy,ny,f,no}
//  alu_o      in   WIDTH  from Calc o
//  alu_zr     in   1      from Calc zr
//  alu_ng     in   1      from Calc ng
//  out_valid  out  1      result valid
//  out_ready  in   1      result consumed when out_valid&&out_ready
//  out_data   out  WIDTH  registered result
//  out_zr     out  1      registered zero flag
//  out_ng     out  1      registered negative flag
//  out_err    out  1      result came from an illegal op
//  level      out  $clog2(DEPTH)+1  FIFO occupancy
// BEHAVIOUR
//  Reset: FIFO empty, level=0, out_valid=0, out_data=0, out_zr=0, out_ng=0, out_err=0, acc=0.
//  Op table -> ctrl: 0 ZERO 101010 | 1 ONE 111111 | 2 NEG1 111010 | 3 X 001100 | 4 Y 110000
//   5 NOTX 001101 | 6 NOTY 110001 | 7 NEGX 001111 | 8 NEGY 110011 | 9 XINC 011111
//   10 YINC 110111 | 11 XDEC 001110 | 12 YDEC 110010 | 13 ADD 000010 | 14 XSUBY 010011
//   15 YSUBX 000111 | 16 AND 000000 | 17 OR 010101.
//   Ops 18-31 are illegal: accepted, driven as ZERO ctrl, result tagged out_err=1.
//  in_ready = (level!=DEPTH); no push-through-full, even if a pop happens in the same cycle.
//  Execute: FIFO head drives alu_x/alu_y/alu_ctrl combinationally.
//   alu_x = head.use_acc ? acc : head.x. Outputs are don't-care (held at head value) when empty.
//  Capture: when level!=0 && (!out_valid || out_ready), on the edge:
//   - out_* <= {alu_o,alu_zr,alu_ng,illegal}, out_valid<=1, acc<=alu_o, pop head.
//  Else if out_valid&&out_ready: out_valid<=0. out_data/flags hold until the next capture.
//  Latency: command accepted at edge N -> out_valid at edge N+1 (FIFO and output empty).
//  Throughput: 1 result/cycle while out_ready=1.
//  Simultaneous push+pop: level unchanged. Writing into the empty FIFO is not visible at the
//   head until the following cycle (registered write).
//  acc updates in result order only, so a chained command always sees the preceding result.
//  acc is not cleared by the output handshake.
//  Pointers wrap modulo DEPTH. Arithmetic wraps modulo 2^WIDTH (Calc behaviour, no overflow flag).
//  rst_n asserted mid-operation: all queued commands and the pending result are discarded
//   immediately; in_ready=1 after release.
// STRUCTURE
//  alu_pkg: op code localparams (OP_ZERO..OP_OR), 6-bit ctrl constants, decode function.
//  Sub-module alu_cmd_fifo (sync FIFO, WIDTH*2+6 bits, async active-low reset).
//  Decode, acc and output register live in this module. Calc is instantiated by the parent.
// TESTING (bench instantiates Calc alongside; monitor logs to file)
//  ADD x=0x76,y=0x2A, out_ready=1 -> out_data=0xA0, ng=1, zr=0, one cycle after accept.
//  XSUBY x=0x55,y=0x9B -> 0xBA, ng=1. AND x=0xFF,y=0xCF -> 0xCF. XDEC x=0x01 -> 0x00, zr=1.
//  Chain: ONE, then XINC use_acc=1, then XINC use_acc=1 (x=0xAA) -> results 0x01,0x02,0x03.
//  Backpressure, DEPTH=4, out_ready=0, stream commands -> 5 accepted, in_ready=0, level=4.
//   Raise out_ready -> 5 results in order, no loss or duplication.
//  Illegal op=25 -> out_data=0x00, zr=1, out_err=1. The next legal op clears out_err.
//  rst_n low while level=3 and out_valid=1 -> out_valid=0, level=0, acc=0 at once.
//   First command after reset is processed normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Op codes, Calc control words and the op decoder shared by the command sequencer.
package alu_pkg;

    localparam int OP_W   = 5;
    localparam int CTRL_W = 6;

    localparam logic [OP_W-1:0] OP_ZERO  = 5'd0;
    localparam logic [OP_W-1:0] OP_ONE   = 5'd1;
    localparam logic [OP_W-1:0] OP_NEG1  = 5'd2;
    localparam logic [OP_W-1:0] OP_X     = 5'd3;
    localparam logic [OP_W-1:0] OP_Y     = 5'd4;
    localparam logic [OP_W-1:0] OP_NOTX  = 5'd5;
    localparam logic [OP_W-1:0] OP_NOTY  = 5'd6;
    localparam logic [OP_W-1:0] OP_NEGX  = 5'd7;
    localparam logic [OP_W-1:0] OP_NEGY  = 5'd8;
    localparam logic [OP_W-1:0] OP_XINC  = 5'd9;
    localparam logic [OP_W-1:0] OP_YINC  = 5'd10;
    localparam logic [OP_W-1:0] OP_XDEC  = 5'd11;
    localparam logic [OP_W-1:0] OP_YDEC  = 5'd12;
    localparam logic [OP_W-1:0] OP_ADD   = 5'd13;
    localparam logic [OP_W-1:0] OP_XSUBY = 5'd14;
    localparam logic [OP_W-1:0] OP_YSUBX = 5'd15;
    localparam logic [OP_W-1:0] OP_AND   = 5'd16;
    localparam logic [OP_W-1:0] OP_OR    = 5'd17;

    // Control words are {zx,nx,zy,ny,f,no}.
    localparam logic [CTRL_W-1:0] CTRL_ZERO  = 6'b101010;
    localparam logic [CTRL_W-1:0] CTRL_ONE   = 6'b111111;
    localparam logic [CTRL_W-1:0] CTRL_NEG1  = 6'b111010;
    localparam logic [CTRL_W-1:0] CTRL_X     = 6'b001100;
    localparam logic [CTRL_W-1:0] CTRL_Y     = 6'b110000;
    localparam logic [CTRL_W-1:0] CTRL_NOTX  = 6'b001101;
    localparam logic [CTRL_W-1:0] CTRL_NOTY  = 6'b110001;
    localparam logic [CTRL_W-1:0] CTRL_NEGX  = 6'b001111;
    localparam logic [CTRL_W-1:0] CTRL_NEGY  = 6'b110011;
    localparam logic [CTRL_W-1:0] CTRL_XINC  = 6'b011111;
    localparam logic [CTRL_W-1:0] CTRL_YINC  = 6'b110111;
    localparam logic [CTRL_W-1:0] CTRL_XDEC  = 6'b001110;
    localparam logic [CTRL_W-1:0] CTRL_YDEC  = 6'b110010;
    localparam logic [CTRL_W-1:0] CTRL_ADD   = 6'b000010;
    localparam logic [CTRL_W-1:0] CTRL_XSUBY = 6'b010011;
    localparam logic [CTRL_W-1:0] CTRL_YSUBX = 6'b000111;
    localparam logic [CTRL_W-1:0] CTRL_AND   = 6'b000000;
    localparam logic [CTRL_W-1:0] CTRL_OR    = 6'b010101;

    function automatic logic op_illegal(input logic [OP_W-1:0] op);
        return op > OP_OR;
    endfunction

    // Illegal ops fall through to ZERO so Calc still produces a defined result.
    function automatic logic [CTRL_W-1:0] decode_op(input logic [OP_W-1:0] op);
        case (op)
            OP_ONE:   return CTRL_ONE;
            OP_NEG1:  return CTRL_NEG1;
            OP_X:     return CTRL_X;
            OP_Y:     return CTRL_Y;
            OP_NOTX:  return CTRL_NOTX;
            OP_NOTY:  return CTRL_NOTY;
            OP_NEGX:  return CTRL_NEGX;
            OP_NEGY:  return CTRL_NEGY;
            OP_XINC:  return CTRL_XINC;
            OP_YINC:  return CTRL_YINC;
            OP_XDEC:  return CTRL_XDEC;
            OP_YDEC:  return CTRL_YDEC;
            OP_ADD:   return CTRL_ADD;
            OP_XSUBY: return CTRL_XSUBY;
            OP_YSUBX: return CTRL_YSUBX;
            OP_AND:   return CTRL_AND;
            OP_OR:    return CTRL_OR;
            default:  return CTRL_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with registered write and combinational head read.
module alu_cmd_fifo #(
    parameter int WIDTH = 22,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // NOTE: the storage array has no reset; level and the pointers alone say which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command-issue stage for the Calc ALU: queues commands, decodes ops, chains via an accumulator
// and registers Calc's result into a valid/ready output port.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OP_W-1:0]          in_op,
    input  logic                     in_use_acc,
    input  logic [WIDTH-1:0]         in_x,
    input  logic [WIDTH-1:0]         in_y,
    output logic [WIDTH-1:0]         alu_x,
    output logic [WIDTH-1:0]         alu_y,
    output logic [CTRL_W-1:0]        alu_ctrl,
    input  logic [WIDTH-1:0]         alu_o,
    input  logic                     alu_zr,
    input  logic                     alu_ng,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_zr,
    output logic                     out_ng,
    output logic                     out_err,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int CMD_W = 2 * WIDTH + OP_W + 1;

    logic [CMD_W-1:0] head;
    logic [OP_W-1:0]  head_op;
    logic             head_use_acc;
    logic [WIDTH-1:0] head_x;
    logic [WIDTH-1:0] head_y;
    logic [WIDTH-1:0] acc;
    logic             push;
    logic             capture;

    // A full FIFO refuses input even when the head is leaving this cycle.
    assign in_ready = (level != LW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign capture  = (level != '0) && (!out_valid || out_ready);

    alu_cmd_fifo #(.WIDTH(CMD_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata ({in_op, in_use_acc, in_x, in_y}),
        .pop   (capture),
        .rdata (head),
        .level (level)
    );

    assign {head_op, head_use_acc, head_x, head_y} = head;

    assign alu_x    = head_use_acc ? acc : head_x;
    assign alu_y    = head_y;
    assign alu_ctrl = decode_op(head_op);

    // NOTE: all state here uses non-blocking assignments so acc read by alu_x is the pre-edge value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_zr    <= 1'b0;
            out_ng    <= 1'b0;
            out_err   <= 1'b0;
            acc       <= '0;
        end else if (capture) begin
            out_valid <= 1'b1;
            out_data  <= alu_o;
            out_zr    <= alu_zr;
            out_ng    <= alu_ng;
            out_err   <= op_illegal(head_op);
            acc       <= alu_o;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
